// File: rtl/alu_pkg.sv
// alu_pkg
//   Definitions shared by the decode/issue stage and the 8-bit ALU.
//   - Datapath, register-file and instruction widths.
//   - 4-bit ALU opcode encodings, plus the decode-only OP_LDI and OP_NOP.
//   - Instruction field bit positions.
//   - ID/EX bundle layout and helpers that report which sources an opcode reads.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int NREG    = 8;
    localparam int INSTR_W = 16;
    localparam int REG_AW  = 3;
    localparam int OPC_W   = 4;

    // Instruction field positions
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS_MSB  = 8;
    localparam int RS_LSB  = 6;
    localparam int RT_MSB  = 5;
    localparam int RT_LSB  = 3;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD = 4'h0,
        OP_SUB = 4'h1,
        OP_MUL = 4'h2,
        OP_DIV = 4'h3,
        OP_AND = 4'h4,
        OP_OR  = 4'h5,
        OP_NOT = 4'h6,
        OP_XOR = 4'h7,
        OP_SHR = 4'h8,
        OP_SHL = 4'h9,
        OP_ROL = 4'hA,
        OP_ROR = 4'hB,
        OP_GT  = 4'hC,
        OP_EQ  = 4'hD,
        OP_LDI = 4'hE,
        OP_NOP = 4'hF
    } opcode_e;

    typedef struct packed {
        logic [OPC_W-1:0]  alu_ctrl;
        logic [DATA_W-1:0] src_a;
        logic [DATA_W-1:0] src_b;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } idex_t;

    // Every ALU opcode reads rs; LDI and NOP read no registers.
    function automatic logic uses_rs(input opcode_e op);
        return (op != OP_LDI) && (op != OP_NOP);
    endfunction

    // NOT is unary, so only the binary ALU opcodes read rt.
    function automatic logic uses_rt(input opcode_e op);
        return (op != OP_LDI) && (op != OP_NOP) && (op != OP_NOT);
    endfunction

endpackage

// File: rtl/reg_file_8x8.sv
// reg_file_8x8
//   8 x 8-bit register file; R0 is hardwired to zero.
//   Ports:
//     clk, rst_n           clock, asynchronous active-low reset (clears all registers)
//     we, waddr, wdata     single write port; writes to R0 are dropped
//     raddr_a / rdata_a    read port A
//     raddr_b / rdata_b    read port B
//   A read of the address being written in the same cycle returns wdata
//   (write-through), so decode sees writeback data without waiting a cycle.
module reg_file_8x8
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0] mem_q [NREG];
    logic [DATA_W-1:0] mem_d [NREG];

    always_comb begin
        mem_d = mem_q;
        if (we && (waddr != '0)) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rdata_a = mem_q[raddr_a];
        if (we && (waddr == raddr_a)) begin
            rdata_a = wdata;
        end
        if (raddr_a == '0) begin
            rdata_a = '0;
        end
    end

    always_comb begin
        rdata_b = mem_q[raddr_b];
        if (we && (waddr == raddr_b)) begin
            rdata_b = wdata;
        end
        if (raddr_b == '0) begin
            rdata_b = '0;
        end
    end

endmodule

// File: rtl/decode_issue.sv
// decode_issue
//   Decode/issue stage in front of the 8-bit ALU.
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     InstrValid/InstrReady/Instr   instruction input handshake (16-bit word)
//     Flush                         squash the ID/EX entry, block acceptance this cycle
//     ExValid/ExReady               ID/EX output handshake
//     SrcA, SrcB, ALUControl,
//     Rd, RegWrite                  registered ID/EX bundle
//     WbEn, WbAddr, WbData          writeback port into the register file
//   A pending-write scoreboard stalls any instruction whose source register
//   has an outstanding write, unless that write lands in the same cycle, in
//   which case the operand is bypassed from WbData.
module decode_issue
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int NREG    = 8,
    parameter int INSTR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    InstrValid,
    output logic                    InstrReady,
    input  logic [INSTR_W-1:0]      Instr,
    input  logic                    Flush,
    input  logic                    ExReady,
    output logic                    ExValid,
    output logic [DATA_W-1:0]       SrcA,
    output logic [DATA_W-1:0]       SrcB,
    output logic [3:0]              ALUControl,
    output logic [$clog2(NREG)-1:0] Rd,
    output logic                    RegWrite,
    input  logic                    WbEn,
    input  logic [$clog2(NREG)-1:0] WbAddr,
    input  logic [DATA_W-1:0]       WbData
);

    opcode_e           op;
    logic [REG_AW-1:0] rd_f;
    logic [REG_AW-1:0] rs_f;
    logic [REG_AW-1:0] rt_f;
    logic [DATA_W-1:0] imm_f;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    logic              hazard;
    logic              accept;
    idex_t             dec;

    logic              ex_valid_q, ex_valid_d;
    idex_t             idex_q, idex_d;
    logic [NREG-1:0]   pending_q, pending_d;

    assign op    = opcode_e'(Instr[OPC_MSB:OPC_LSB]);
    assign rd_f  = Instr[RD_MSB:RD_LSB];
    assign rs_f  = Instr[RS_MSB:RS_LSB];
    assign rt_f  = Instr[RT_MSB:RT_LSB];
    assign imm_f = Instr[IMM_MSB:IMM_LSB];

    reg_file_8x8 u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (WbEn),
        .waddr   (WbAddr),
        .wdata   (WbData),
        .raddr_a (rs_f),
        .rdata_a (rdata_a),
        .raddr_b (rt_f),
        .rdata_b (rdata_b)
    );

    // A pending source is only a hazard if its writeback is not arriving
    // this cycle; when it is, the register file forwards WbData.
    always_comb begin
        hazard = 1'b0;
        if (uses_rs(op) && pending_q[rs_f] && !(WbEn && (WbAddr == rs_f))) begin
            hazard = 1'b1;
        end
        if (uses_rt(op) && pending_q[rt_f] && !(WbEn && (WbAddr == rt_f))) begin
            hazard = 1'b1;
        end
    end

    // Deliberately independent of InstrValid.
    assign InstrReady = !Flush && !hazard && (!ex_valid_q || ExReady);
    assign accept     = InstrValid && InstrReady;

    always_comb begin
        dec = '0;
        unique case (op)
            OP_LDI: begin
                dec.alu_ctrl  = OP_OR;
                dec.src_a     = '0;
                dec.src_b     = imm_f;
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
            end
            OP_NOP: begin
                dec = '0;
            end
            default: begin
                dec.alu_ctrl  = Instr[OPC_MSB:OPC_LSB];
                dec.src_a     = rdata_a;
                dec.src_b     = rdata_b;
                dec.rd        = rd_f;
                dec.reg_write = 1'b1;
            end
        endcase
    end

    always_comb begin
        ex_valid_d = ex_valid_q;
        idex_d     = idex_q;
        if (accept) begin
            ex_valid_d = 1'b1;
            idex_d     = dec;
        end else if (Flush || ExReady) begin
            ex_valid_d = 1'b0;
        end
    end

    // Priority: writeback clear, then squash clear, then issue set, so a set
    // and clear of the same register in one cycle leaves it pending.
    always_comb begin
        pending_d = pending_q;
        if (WbEn) begin
            pending_d[WbAddr] = 1'b0;
        end
        if (Flush && ex_valid_q && !ExReady && idex_q.reg_write) begin
            pending_d[idex_q.rd] = 1'b0;
        end
        if (accept && dec.reg_write && (dec.rd != '0)) begin
            pending_d[dec.rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q <= 1'b0;
            idex_q     <= '0;
            pending_q  <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            idex_q     <= idex_d;
            pending_q  <= pending_d;
        end
    end

    assign ExValid    = ex_valid_q;
    assign SrcA       = idex_q.src_a;
    assign SrcB       = idex_q.src_b;
    assign ALUControl = idex_q.alu_ctrl;
    assign Rd         = idex_q.rd;
    assign RegWrite   = idex_q.reg_write;

endmodule

// File: doc/decode_issue.md
# decode_issue

Instruction decode and issue stage feeding the 8-bit ALU in the pipelined datapath. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8x8 register file with writeback bypass. It tracks pending register writes in a scoreboard and stalls on RAW hazards. It drives a registered ID/EX bundle (SrcA, SrcB, ALUControl, Rd, RegWrite) to the execute stage over a second valid/ready handshake.

## Interface
- DATA_W, 8, operand/register width
- NREG, 8, register count (R0 reads as zero)
- INSTR_W, 16, instruction width

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- InstrValid  in  1  Instr holds a valid instruction
- InstrReady  out  1  stage accepts Instr this cycle
- Instr  in  16  instruction word
- Flush  in  1  squash ID/EX register contents
- ExReady  in  1  execute stage accepts ID/EX bundle
- ExValid  out  1  ID/EX bundle valid
- SrcA  out  8  ALU operand A
- SrcB  out  8  ALU operand B
- ALUControl  out  4  ALU operation code
- Rd  out  3  destination register
- RegWrite  out  1  instruction writes Rd
- WbEn  in  1  writeback strobe
- WbAddr  in  3  writeback register
- WbData  in  8  writeback data

## Operation
- Instruction format: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [2:0] ignored. Exception: LDI uses imm8 = [7:0].
- Opcodes 0000–1101 pass through unchanged to ALUControl: ADD, SUB, MUL, DIV, AND, OR, NOT, XOR, SHR, SHL, ROL, ROR, GT, EQ. All set RegWrite=1.
- 1110 LDI: ALUControl=0101 (OR), SrcA=0, SrcB=imm8, RegWrite=1. Only rd is used, so no source hazard check.
- 1111 NOP: issued with RegWrite=0, ALUControl=0000, SrcA=SrcB=0.
- Register file: 8x8, reset to all zero. Written on WbEn. Writes to R0 are ignored, and R0 always reads 0.
- Bypass: if WbEn and WbAddr==rs (or rt), and the address is nonzero, the operand takes WbData in the same cycle.
- Scoreboard: 8 pending bits, bit 0 always 0.
  - Set for Rd when an instruction with RegWrite=1 and Rd!=0 is accepted.
  - Cleared on WbEn for WbAddr.
  - Set and clear on the same register in the same cycle: set wins.
- Hazard: the stage stalls if rs or rt (per opcode use) is pending and not being written back this cycle. NOT uses rs only.
- Handshake:
  - InstrReady = !Flush && !hazard && (!ExValid || ExReady).
  - Accept when InstrValid && InstrReady. The ID/EX register loads and ExValid is set.
  - If ExValid && ExReady and nothing is accepted, ExValid clears.
  - If ExValid && !ExReady, all ID/EX outputs hold stable.
- Flush: ExValid clears next cycle and no instruction is accepted that cycle. If the squashed entry had RegWrite=1, its Rd pending bit clears, unless the entry is being consumed by ExReady that cycle.

## Timing
- Reset: ExValid=0, SrcA=SrcB=0, ALUControl=0, Rd=0, RegWrite=0, scoreboard=0, registers=0. InstrReady follows its equation and is 1 out of reset.
- Decode latency: 1 cycle from accept edge to ExValid.
- Throughput: one instruction per cycle with no hazards and ExReady=1.
- RAW on the immediately preceding instruction stalls until its WbEn cycle. Issue happens in that cycle, with the bypassed operand.
- InstrReady is combinational from ExValid, ExReady, Flush, scoreboard, WbEn/WbAddr, and Instr fields. No combinational path runs from InstrValid to InstrReady.
- Reset asserted mid-operation discards the in-flight bundle and all pending bits immediately.

## Structure
- Shared package alu_pkg:
  - 4-bit opcode constants, shared with the ALU.
  - OP_LDI and OP_NOP.
  - Instruction field bit positions.
  - DATA_W.
- Sub-module reg_file_8x8: two read ports with write-through bypass, one write port, R0 hardwired to zero.
- Scoreboard, hazard logic, and the ID/EX register live in decode_issue.

## Test plan
- Reset, then LDI R1,0x2A with ExReady=1 -> next cycle ExValid=1, ALUControl=0101, SrcA=0, SrcB=0x2A, Rd=1, RegWrite=1.
- LDI R1, then ADD R2,R1,R1 back-to-back -> InstrReady=0 until WbEn R1=0x2A. In the WbEn cycle, ADD issues with SrcA=SrcB=0x2A.
- ExReady=0 with ExValid=1 for 3 cycles -> outputs held, InstrReady=0. ExReady=1 -> next instruction accepted that cycle.
- Flush while an LDI R3 bundle is valid and ExReady=0 -> ExValid=0 next cycle, R3 not pending. Subsequent XOR using R3 issues without stall.
- WbEn to R0 with 0xFF, then SUB R4,R0,R0 -> SrcA=SrcB=0. WbEn R5 and LDI R5 in the same cycle -> R5 remains pending.
- Random opcode 0000–1101 stream with an ExReady toggle -> ALUControl equals opcode, with no drops or duplicates.
